// File: rtl/ldl_rr_arb_pkg.sv
//==============================================================================
// Package  : ldl_rr_arb_pkg
// Purpose  : Shared state encoding and modular helper for ldl_rr_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ldl_rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [1:0] c_ST_IDLE   = IDLE;
  localparam logic [1:0] c_ST_GRANT  = GRANT;
  localparam logic [1:0] c_ST_LOCKED = LOCKED;

  // Valid only for a, b < n: a single conditional subtract replaces a divider.
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ldl_rr_arbiter_if.sv
//==============================================================================
// Interface : ldl_rr_arbiter_if
// Purpose   : Request / grant handshake bundle between requesters and arbiter.
// Revision  : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ldl_rr_arbiter_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic          gnt_rdy;
  logic          lock;
  logic          gnt_vld;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;

  modport master (output req, gnt_rdy, lock, input gnt_vld, gnt, gnt_id);
  modport slave  (input req, gnt_rdy, lock, output gnt_vld, gnt, gnt_id);
endinterface

`default_nettype wire

// File: rtl/ldl_ffs.sv
//==============================================================================
// Module   : ldl_ffs
// Purpose  : Find-first-set: index of the lowest set bit plus a found flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ldl_ffs #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);
  always_comb begin
    o_idx   = '0;
    o_found = |i_vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
  end
endmodule

`default_nettype wire

// File: rtl/ldl_ring_shift.sv
//==============================================================================
// Module   : ldl_ring_shift
// Purpose  : Combinational ring rotate; i_dir=0 rotates right (bit step -> bit 0).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ldl_ring_shift #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SW-1:0]    i_step,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_data
);
  localparam logic [SW:0] c_W = (SW+1)'(WIDTH);

  logic [SW:0] w_ofs;
  logic [SW:0] w_src;

  // Left rotate is a right rotate by WIDTH-step; i_step must be < WIDTH.
  always_comb begin
    w_ofs  = i_dir ? (c_W - {1'b0, i_step}) : {1'b0, i_step};
    w_src  = '0;
    o_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_src = (SW+1)'(i) + w_ofs;
      if (w_src >= c_W) w_src = w_src - c_W;
      o_data[i] = i_data[w_src[SW-1:0]];
    end
  end
endmodule

`default_nettype wire

// File: rtl/ldl_rr_arbiter.sv
//==============================================================================
// Module   : ldl_rr_arbiter
// Purpose  : Round-robin arbiter with registered one-hot grant and valid/ready
//            grant handshake. Owner lock is built only when LDL_RR_ARB_LOCK_EN
//            is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ldl_rr_arbiter
  import ldl_rr_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  ldl_rr_arbiter_if.slave bus
);
  localparam int            IW    = $clog2(N);
  localparam logic [IW:0]   c_N   = (IW+1)'(N);
  localparam logic [N-1:0]  c_ONE = N'(1);
`ifdef LDL_RR_ARB_LOCK_EN
  localparam bit            c_LOCK_EN = 1'b1;
`else
  localparam bit            c_LOCK_EN = 1'b0;
`endif

  logic [1:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_gnt_id;
  logic [N-1:0]  r_gnt;
  logic          r_gnt_vld;

  logic          w_hs;
  logic          w_lock_hs;
  logic          w_lock_hold;
  logic [N-1:0]  w_owner_mask;
  logic [N-1:0]  w_elig;
  logic [IW-1:0] w_ptr_inc;
  logic [IW-1:0] w_arb_ptr;
  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_k;
  logic          w_found;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_win;
  logic [N-1:0]  w_win_1h;

  assign w_hs         = r_gnt_vld & bus.gnt_rdy;
  assign w_lock_hs    = c_LOCK_EN & w_hs & bus.lock;
  assign w_lock_hold  = c_LOCK_EN & (r_state == c_ST_LOCKED) & ~w_hs;
  assign w_owner_mask = c_ONE << r_gnt_id;
  assign w_ptr_inc    = IW'(mod_add(32'(r_gnt_id), 32'd1, N));
  // On a handshake the next winner is searched from just past the current owner.
  assign w_arb_ptr    = w_hs ? w_ptr_inc : r_ptr;

  always_comb begin
    w_elig = bus.req;
    if (w_lock_hs || w_lock_hold) w_elig = bus.req & w_owner_mask;
    else if (w_hs)                w_elig = bus.req & ~r_gnt;
  end

  ldl_ring_shift #(.WIDTH(N), .SW(IW)) u_rot (
    .i_data (w_elig),
    .i_step (w_arb_ptr),
    .i_dir  (1'b0),
    .o_data (w_rot)
  );

  ldl_ffs #(.N(N), .IW(IW)) u_ffs (
    .i_vec   (w_rot),
    .o_idx   (w_k),
    .o_found (w_found)
  );

  always_comb begin
    w_sum = {1'b0, w_arb_ptr} + {1'b0, w_k};
    if (w_sum >= c_N) w_sum = w_sum - c_N;
    w_win    = w_sum[IW-1:0];
    w_win_1h = c_ONE << w_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_ptr     <= '0;
      r_gnt_id  <= '0;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
    end else if (w_hs) begin
      if (w_lock_hs) begin
        r_state   <= c_ST_LOCKED;
        r_gnt_vld <= w_found;
        r_gnt     <= w_found ? w_win_1h : '0;
      end else begin
        r_ptr <= w_ptr_inc;
        if (w_found) begin
          r_gnt    <= w_win_1h;
          r_gnt_id <= w_win;
          r_state  <= c_ST_GRANT;
        end else begin
          r_gnt_vld <= 1'b0;
          r_gnt     <= '0;
          r_state   <= c_ST_IDLE;
        end
      end
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_found) begin
            r_gnt_vld <= 1'b1;
            r_gnt     <= w_win_1h;
            r_gnt_id  <= w_win;
            r_state   <= c_ST_GRANT;
          end
        end
`ifdef LDL_RR_ARB_LOCK_EN
        c_ST_LOCKED: begin
          if (!r_gnt_vld) begin
            if (w_found) begin
              r_gnt_vld <= 1'b1;
              r_gnt     <= w_win_1h;
            end else begin
              r_state <= c_ST_IDLE;
              r_ptr   <= w_ptr_inc;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.gnt_vld = r_gnt_vld;
  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
endmodule

`default_nettype wire
